// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings for burst type, response code and transfer size.
package axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam logic [2:0] SIZE_4B     = 3'd2;

endpackage

// File: rtl/axi4_ifc.sv
// AXI4 bundle: 32-bit data and address, IWIDTH-bit IDs.
interface axi4_ifc #(
  parameter int IWIDTH = 5
) ();

  logic [IWIDTH-1:0] awid;
  logic [31:0]       awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic [3:0]        awqos;
  logic              awvalid;
  logic              awready;

  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [IWIDTH-1:0] bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [IWIDTH-1:0] arid;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic              arvalid;
  logic              arready;

  logic [IWIDTH-1:0] rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/sram_dp_be.sv
// Synchronous 32-bit RAM: one byte-enabled write port, one read port, read-before-write.
module sram_dp_be #(
  parameter int AWIDTH = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        be_i,
  input  logic              re_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**AWIDTH];

  // Read output only updates on re_i so it holds while the consumer stalls.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_o <= mem_q[raddr_i];
    if (we_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/axi4_sram_slave.sv
// AXI4 burst slave over an internal dual-port SRAM; independent read and write FSMs.
module axi4_sram_slave
  import axi4_pkg::*;
#(
  parameter int IWIDTH = 5,
  parameter int AWIDTH = 10
) (
  input logic   clk,
  input logic   reset,
  axi4_ifc.slave s
);

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [0:0]        r_state_q, r_state_d;
  logic [AWIDTH-1:0] r_addr_q, r_addr_d, r_next;
  logic [7:0]        r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [IWIDTH-1:0] r_id_q, r_id_d;
  logic [1:0]        r_burst_q, r_burst_d;
  logic              r_last, rd_en;
  logic [AWIDTH-1:0] rd_addr;
  logic [31:0]       rd_data;

  logic [1:0]        w_state_q, w_state_d;
  logic [AWIDTH-1:0] w_addr_q, w_addr_d;
  logic [IWIDTH-1:0] w_id_q, w_id_d;
  logic [1:0]        w_burst_q, w_burst_d;
  logic              wr_en;

  logic              unused_ok;

  assign unused_ok = ^{s.awlen, s.awsize, s.awlock, s.awcache, s.awprot, s.awqos,
                       s.arsize, s.arlock, s.arcache, s.arprot, s.arqos,
                       s.awaddr[31:AWIDTH+2], s.awaddr[1:0],
                       s.araddr[31:AWIDTH+2], s.araddr[1:0]};

  assign r_last = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);
  assign r_next = (r_burst_q == BURST_FIXED) ? r_addr_q : r_addr_q + AWIDTH'(1);

  // Read FSM; the RAM is read on the AR handshake and on each accepted non-last
  // beat, so the next word is already in the RAM output register when needed.
  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_id_d    = r_id_q;
    r_burst_d = r_burst_q;
    rd_en     = 1'b0;
    rd_addr   = r_addr_q;
    case (r_state_q)
      R_IDLE: begin
        if (s.arvalid) begin
          r_addr_d  = s.araddr[AWIDTH+1:2];
          r_len_d   = s.arlen;
          r_cnt_d   = '0;
          r_id_d    = s.arid;
          r_burst_d = s.arburst;
          r_state_d = R_DATA;
          rd_en     = 1'b1;
          rd_addr   = s.araddr[AWIDTH+1:2];
        end
      end
      default: begin
        if (s.rready) begin
          if (r_last) begin
            r_state_d = R_IDLE;
          end else begin
            r_addr_d = r_next;
            r_cnt_d  = r_cnt_q + 8'd1;
            rd_en    = 1'b1;
            rd_addr  = r_next;
          end
        end
      end
    endcase
  end

  // Read channel state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_id_q    <= '0;
      r_burst_q <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_id_q    <= r_id_d;
      r_burst_q <= r_burst_d;
    end
  end

  // Write FSM; wlast alone ends the burst, awlen is not tracked.
  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_id_d    = w_id_q;
    w_burst_d = w_burst_q;
    wr_en     = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s.awvalid) begin
          w_addr_d  = s.awaddr[AWIDTH+1:2];
          w_id_d    = s.awid;
          w_burst_d = s.awburst;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s.wvalid) begin
          wr_en    = 1'b1;
          w_addr_d = (w_burst_q == BURST_FIXED) ? w_addr_q : w_addr_q + AWIDTH'(1);
          if (s.wlast) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write channel state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_id_q    <= '0;
      w_burst_q <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_id_q    <= w_id_d;
      w_burst_q <= w_burst_d;
    end
  end

  sram_dp_be #(.AWIDTH(AWIDTH)) u_ram (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (w_addr_q),
    .wdata_i (s.wdata),
    .be_i    (s.wstrb),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign s.arready = (r_state_q == R_IDLE);
  assign s.rvalid  = (r_state_q == R_DATA);
  assign s.rlast   = r_last;
  assign s.rdata   = rd_data;
  assign s.rid     = r_id_q;
  assign s.rresp   = RESP_OKAY;

  assign s.awready = (w_state_q == W_IDLE);
  assign s.wready  = (w_state_q == W_DATA);
  assign s.bvalid  = (w_state_q == W_RESP);
  assign s.bid     = w_id_q;
  assign s.bresp   = RESP_OKAY;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed plus randomized bench for axi4_sram_slave against a word-array memory model.
module tb_axi4_sram_slave;
  import axi4_pkg::*;

  localparam int IW    = 5;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axi4_ifc #(.IWIDTH(IW)) s_if ();

  axi4_sram_slave #(.IWIDTH(IW), .AWIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (s_if)
  );

  int unsigned total  = 0;
  int unsigned passed = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  task automatic idle_inputs();
    s_if.awid = '0; s_if.awaddr = '0; s_if.awlen = '0; s_if.awsize = SIZE_4B;
    s_if.awburst = BURST_INCR; s_if.awlock = 1'b0; s_if.awcache = '0; s_if.awprot = '0;
    s_if.awqos = '0; s_if.awvalid = 1'b0;
    s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = 1'b0; s_if.wvalid = 1'b0;
    s_if.bready = 1'b0;
    s_if.arid = '0; s_if.araddr = '0; s_if.arlen = '0; s_if.arsize = SIZE_4B;
    s_if.arburst = BURST_INCR; s_if.arlock = 1'b0; s_if.arcache = '0; s_if.arprot = '0;
    s_if.arqos = '0; s_if.arvalid = 1'b0;
    s_if.rready = 1'b0;
  endtask

  // Writes wd/ws[0..n-1]; bready is withheld for bdelay cycles once bvalid is due.
  task automatic write_burst(input logic [31:0] addr, input logic [IW-1:0] id,
                             input logic [1:0] burst, input int unsigned n,
                             input int unsigned bdelay);
    int unsigned w;
    int unsigned cyc;
    w = widx(addr);
    @(negedge clk);
    s_if.awvalid = 1'b1; s_if.awaddr = addr; s_if.awid = id;
    s_if.awlen = 8'(n - 1); s_if.awburst = burst;
    s_if.awsize = $urandom_range(0, 1) ? SIZE_4B : 3'd0;
    cyc = 0;
    while (!s_if.awready && cyc < 50) begin @(negedge clk); cyc++; end
    check("aw_ready", 32'(s_if.awready), 32'd1);
    @(negedge clk);
    s_if.awvalid = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      s_if.wvalid = 1'b1; s_if.wdata = wd[i]; s_if.wstrb = ws[i]; s_if.wlast = (i == n - 1);
      cyc = 0;
      while (!s_if.wready && cyc < 50) begin @(negedge clk); cyc++; end
      if (!s_if.wready) begin
        check("w_ready_timeout", 32'(s_if.wready), 32'd1);
        break;
      end
      @(negedge clk);
      for (int unsigned b = 0; b < 4; b++)
        if (ws[i][b]) model[w][8*b +: 8] = wd[i][8*b +: 8];
      if (burst != BURST_FIXED) w = (w + 1) % DEPTH;
    end
    s_if.wvalid = 1'b0; s_if.wlast = 1'b0;
    for (int unsigned d = 0; d < bdelay; d++) begin
      check("bvalid_hold", 32'(s_if.bvalid), 32'd1);
      check("awready_in_resp", 32'(s_if.awready), 32'd0);
      @(negedge clk);
    end
    s_if.bready = 1'b1;
    cyc = 0;
    while (!s_if.bvalid && cyc < 50) begin @(negedge clk); cyc++; end
    check("bvalid", 32'(s_if.bvalid), 32'd1);
    check("bresp", 32'(s_if.bresp), 32'(RESP_OKAY));
    check("bid", 32'(s_if.bid), 32'(id));
    @(negedge clk);
    s_if.bready = 1'b0;
    check("bvalid_clear", 32'(s_if.bvalid), 32'd0);
  endtask

  // mode 0: rready=1, 1: rready pattern 1,0,0,1, 2: random rready.
  // Stops after stop_after accepted beats, leaving the rest in flight.
  task automatic read_burst(input logic [31:0] addr, input logic [IW-1:0] id,
                            input logic [1:0] burst, input int unsigned len,
                            input int unsigned mode, input int unsigned stop_after);
    int unsigned w, beat, cyc, want;
    logic        rr, held;
    logic [31:0] held_data;
    w = widx(addr);
    @(negedge clk);
    s_if.arvalid = 1'b1; s_if.araddr = addr; s_if.arid = id;
    s_if.arlen = 8'(len); s_if.arburst = burst;
    s_if.arsize = $urandom_range(0, 1) ? SIZE_4B : 3'd1;
    cyc = 0;
    while (!s_if.arready && cyc < 50) begin @(negedge clk); cyc++; end
    check("ar_ready", 32'(s_if.arready), 32'd1);
    @(negedge clk);
    s_if.arvalid = 1'b0;
    want = (len + 1 < stop_after) ? len + 1 : stop_after;
    beat = 0; cyc = 0; held = 1'b0; held_data = '0;
    while (beat < want && cyc < 3000) begin
      case (mode)
        0:       rr = 1'b1;
        1:       rr = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rr = ($urandom_range(0, 3) != 0);
      endcase
      s_if.rready = rr;
      if (held) begin
        check("rvalid_stall", 32'(s_if.rvalid), 32'd1);
        check("rdata_stall", s_if.rdata, held_data);
        held = 1'b0;
      end
      if (s_if.rvalid) begin
        if (rr) begin
          check("rdata", s_if.rdata, model[w]);
          check("rid", 32'(s_if.rid), 32'(id));
          check("rresp", 32'(s_if.rresp), 32'(RESP_OKAY));
          check("rlast", 32'(s_if.rlast), 32'(beat == len));
          last_rdata = s_if.rdata;
          beat++;
          if (burst != BURST_FIXED) w = (w + 1) % DEPTH;
        end else begin
          held = 1'b1;
          held_data = s_if.rdata;
        end
      end
      @(negedge clk);
      cyc++;
    end
    s_if.rready = 1'b0;
    check("read_beats", 32'(beat), 32'(want));
  endtask

  initial begin
    logic [31:0] a_addr, b_addr;
    logic        rgot, wdone;
    int unsigned cyc, len;
    logic [1:0]  bt;

    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_awready", 32'(s_if.awready), 32'd1);
    check("rst_arready", 32'(s_if.arready), 32'd1);
    check("rst_wready", 32'(s_if.wready), 32'd0);
    check("rst_bvalid", 32'(s_if.bvalid), 32'd0);
    check("rst_rvalid", 32'(s_if.rvalid), 32'd0);
    check("rst_rlast", 32'(s_if.rlast), 32'd0);
    check("rst_bresp", 32'(s_if.bresp), 32'd0);
    check("rst_rresp", 32'(s_if.rresp), 32'd0);
    check("rst_bid", 32'(s_if.bid), 32'd0);
    check("rst_rid", 32'(s_if.rid), 32'd0);

    // Fill all memory with known random data using maximum-length bursts.
    for (int unsigned k = 0; k < 4; k++) begin
      for (int unsigned i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      write_burst(32'(k * 1024), 5'(k), BURST_INCR, 256, 0);
    end
    read_burst(32'h400, 5'h11, BURST_INCR, 255, 2, 999);

    // Basic 8-beat write then read-back.
    for (int unsigned i = 0; i < 8; i++) begin wd[i] = 32'h1000 + 32'(i); ws[i] = 4'hF; end
    write_burst(32'h0, 5'h03, BURST_INCR, 8, 0);
    read_burst(32'h0, 5'h09, BURST_INCR, 7, 0, 999);
    check("burst_last_word", last_rdata, 32'h1007);

    // Byte strobe merge.
    wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
    write_burst(32'h10, 5'h01, BURST_INCR, 1, 0);
    wd[0] = 32'h11223344; ws[0] = 4'h5;
    write_burst(32'h10, 5'h02, BURST_INCR, 1, 0);
    read_burst(32'h10, 5'h04, BURST_INCR, 0, 0, 999);
    check("strobe_merge", last_rdata, 32'hAA22CC44);

    // Read backpressure and B-channel backpressure.
    read_burst(32'h0, 5'h1F, BURST_INCR, 3, 1, 999);
    for (int unsigned i = 0; i < 3; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    write_burst(32'h100, 5'h15, BURST_INCR, 3, 5);
    read_burst(32'h100, 5'h15, BURST_INCR, 2, 0, 999);

    // Address wrap at the top of memory.
    wd[0] = 32'hCAFE0001; wd[1] = 32'hCAFE0002; ws[0] = 4'hF; ws[1] = 4'hF;
    write_burst(32'hFFC, 5'h06, BURST_INCR, 2, 0);
    read_burst(32'h0, 5'h06, BURST_INCR, 0, 0, 999);
    check("wrap_word0", last_rdata, 32'hCAFE0002);
    read_burst(32'hFFC, 5'h07, BURST_WRAP, 1, 0, 999);

    // FIXED write: last beat wins at the single address.
    for (int unsigned i = 0; i < 4; i++) begin wd[i] = 32'hF1C5_0000 + 32'(i); ws[i] = 4'hF; end
    write_burst(32'h20, 5'h08, BURST_FIXED, 4, 0);
    read_burst(32'h20, 5'h08, BURST_INCR, 0, 0, 999);
    check("fixed_last_beat", last_rdata, 32'hF1C5_0003);
    read_burst(32'h20, 5'h0A, BURST_FIXED, 3, 1, 999);

    // Concurrent AR and AW in the same cycle, single beats each.
    a_addr = 32'h200; b_addr = 32'h300;
    @(negedge clk);
    s_if.awvalid = 1'b1; s_if.awaddr = a_addr; s_if.awid = 5'h0C; s_if.awlen = 8'd0;
    s_if.awburst = BURST_INCR;
    s_if.arvalid = 1'b1; s_if.araddr = b_addr; s_if.arid = 5'h0D; s_if.arlen = 8'd0;
    s_if.arburst = BURST_INCR;
    check("conc_awready", 32'(s_if.awready), 32'd1);
    check("conc_arready", 32'(s_if.arready), 32'd1);
    @(negedge clk);
    s_if.awvalid = 1'b0; s_if.arvalid = 1'b0;
    s_if.wdata = 32'h5A5A_1234; s_if.wstrb = 4'hF; s_if.wlast = 1'b1;
    rgot = 1'b0; wdone = 1'b0; cyc = 0;
    while (!(rgot && wdone) && cyc < 20) begin
      s_if.rready = !rgot;
      s_if.wvalid = !wdone;
      if (s_if.rvalid && !rgot) begin
        check("conc_rdata", s_if.rdata, model[widx(b_addr)]);
        check("conc_rlast", 32'(s_if.rlast), 32'd1);
        rgot = 1'b1;
      end
      if (s_if.wready && !wdone) wdone = 1'b1;
      @(negedge clk);
      cyc++;
    end
    s_if.rready = 1'b0; s_if.wvalid = 1'b0; s_if.wlast = 1'b0;
    check("conc_done", 32'(rgot && wdone), 32'd1);
    model[widx(a_addr)] = 32'h5A5A_1234;
    s_if.bready = 1'b1;
    cyc = 0;
    while (!s_if.bvalid && cyc < 20) begin @(negedge clk); cyc++; end
    check("conc_bvalid", 32'(s_if.bvalid), 32'd1);
    check("conc_bid", 32'(s_if.bid), 32'h0C);
    @(negedge clk);
    s_if.bready = 1'b0;
    read_burst(a_addr, 5'h0C, BURST_INCR, 0, 0, 999);
    read_burst(b_addr, 5'h0D, BURST_INCR, 0, 0, 999);

    // Reset in the middle of a read burst.
    read_burst(32'h0, 5'h12, BURST_INCR, 3, 0, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_rvalid", 32'(s_if.rvalid), 32'd0);
    check("midrst_arready", 32'(s_if.arready), 32'd1);
    check("midrst_rlast", 32'(s_if.rlast), 32'd0);
    read_burst(32'h0, 5'h13, BURST_INCR, 7, 0, 999);

    // Randomized write/read-back bursts.
    for (int unsigned it = 0; it < 12; it++) begin
      a_addr = $urandom;
      len    = $urandom_range(0, 15);
      bt     = 2'($urandom_range(0, 2));
      for (int unsigned i = 0; i <= len; i++) begin
        wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15));
      end
      write_burst(a_addr, 5'($urandom_range(0, 31)), bt, len + 1, $urandom_range(0, 2));
      read_burst(a_addr, 5'($urandom_range(0, 31)), bt, len, 2, 999);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
